// File: rtl/qenc_pkg.sv
// Shared definitions for the quadrature encoder bank: detent FSM state
// encoding, resolution selectors and the Gray-code position helper.
package qenc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CW1    = 3'd1,
    ST_CW2    = 3'd2,
    ST_CW3    = 3'd3,
    ST_CCW1   = 3'd4,
    ST_CCW2   = 3'd5,
    ST_CCW3   = 3'd6,
    ST_RESYNC = 3'd7
  } qenc_state_e;

  localparam int RES_DETENT = 1;
  localparam int RES_EDGE   = 4;

  // Position of a {A,B} code along the clockwise order 00,10,11,01.
  function automatic logic [1:0] gray_idx(input logic [1:0] code);
    logic [1:0] idx;
    case (code)
      2'b00:   idx = 2'd0;
      2'b10:   idx = 2'd1;
      2'b11:   idx = 2'd2;
      2'b01:   idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/qenc_channel.sv
// One encoder channel: 2-FF synchroniser, stability filter, detent/edge
// decoder and position counter. QENC_SATURATE_EN selects saturating counting.
module qenc_channel
  import qenc_pkg::*;
#(
  parameter int CNT_WIDTH  = 8,
  parameter int FILTER_LEN = 4,
  parameter int RES        = RES_DETENT
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_a,
  input  logic                 i_b,
  input  logic                 i_clr,
  output logic                 o_step,
  output logic                 o_step_cw,
  output logic [CNT_WIDTH-1:0] o_pos,
  output logic                 o_err
);

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam logic [FCW-1:0] FMAX = FCW'(FILTER_LEN);
  localparam logic [FCW-1:0] FONE = FCW'(1);
  localparam logic [CNT_WIDTH-1:0] PONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] PMAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] PMIN = {CNT_WIDTH{1'b0}};

  logic [1:0]           sync1_q, sync1_d, sync2_q, sync2_d;
  logic [1:0]           cand_q, cand_d, filt_q, filt_d, last_q, last_d;
  logic [FCW-1:0]       fcnt_q, fcnt_d;
  qenc_state_e          state_q, state_d;
  logic [CNT_WIDTH-1:0] pos_q, pos_d;
  logic                 step_q, step_d, cw_q, cw_d, err_q, err_d;
  logic                 inc, dec, bad;
  logic [1:0]           delta;

  // Synchroniser and filter: a code is accepted once seen FILTER_LEN samples in a row.
  always_comb begin
    sync1_d = {i_a, i_b};
    sync2_d = sync1_q;
    cand_d  = sync2_q;
    fcnt_d  = fcnt_q;
    if (sync2_q != cand_q) begin
      fcnt_d = FONE;
    end else if (fcnt_q != FMAX) begin
      fcnt_d = fcnt_q + FONE;
    end else begin
      fcnt_d = fcnt_q;
    end
    if (fcnt_d == FMAX) begin
      filt_d = sync2_q;
    end else begin
      filt_d = filt_q;
    end
    last_d = filt_q;
  end

  // Decoder: full-detent FSM, or per-edge Gray stepping against the previous code.
  always_comb begin
    state_d = state_q;
    inc     = 1'b0;
    dec     = 1'b0;
    bad     = 1'b0;
    delta   = gray_idx(filt_q) - gray_idx(last_q);
    if (RES == RES_EDGE) begin
      state_d = ST_IDLE;
      case (delta)
        2'd1:    inc = 1'b1;
        2'd3:    dec = 1'b1;
        2'd2:    bad = 1'b1;
        default: inc = 1'b0;
      endcase
    end else begin
      case (state_q)
        ST_IDLE: case (filt_q)
          2'b10:   state_d = ST_CW1;
          2'b01:   state_d = ST_CCW1;
          2'b11:   begin bad = 1'b1; state_d = ST_RESYNC; end
          default: state_d = ST_IDLE;
        endcase
        ST_CW1: case (filt_q)
          2'b11:   state_d = ST_CW2;
          2'b00:   state_d = ST_IDLE;
          2'b01:   begin bad = 1'b1; state_d = ST_RESYNC; end
          default: state_d = ST_CW1;
        endcase
        ST_CW2: case (filt_q)
          2'b01:   state_d = ST_CW3;
          2'b10:   state_d = ST_CW1;
          2'b00:   begin bad = 1'b1; state_d = ST_RESYNC; end
          default: state_d = ST_CW2;
        endcase
        ST_CW3: case (filt_q)
          2'b00:   begin inc = 1'b1; state_d = ST_IDLE; end
          2'b11:   state_d = ST_CW2;
          2'b10:   begin bad = 1'b1; state_d = ST_RESYNC; end
          default: state_d = ST_CW3;
        endcase
        ST_CCW1: case (filt_q)
          2'b11:   state_d = ST_CCW2;
          2'b00:   state_d = ST_IDLE;
          2'b10:   begin bad = 1'b1; state_d = ST_RESYNC; end
          default: state_d = ST_CCW1;
        endcase
        ST_CCW2: case (filt_q)
          2'b10:   state_d = ST_CCW3;
          2'b01:   state_d = ST_CCW1;
          2'b00:   begin bad = 1'b1; state_d = ST_RESYNC; end
          default: state_d = ST_CCW2;
        endcase
        ST_CCW3: case (filt_q)
          2'b00:   begin dec = 1'b1; state_d = ST_IDLE; end
          2'b11:   state_d = ST_CCW2;
          2'b01:   begin bad = 1'b1; state_d = ST_RESYNC; end
          default: state_d = ST_CCW3;
        endcase
        ST_RESYNC: begin
          if (filt_q == 2'b00) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_RESYNC;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Position counter, step pulse, direction and sticky error; clear overrides counting.
  always_comb begin
    pos_d  = pos_q;
    cw_d   = cw_q;
    err_d  = err_q;
    step_d = inc | dec;
    if (inc) begin
      cw_d = 1'b1;
`ifdef QENC_SATURATE_EN
      if (pos_q != PMAX) begin
        pos_d = pos_q + PONE;
      end else begin
        pos_d = pos_q;
      end
`else
      pos_d = pos_q + PONE;
`endif
    end else if (dec) begin
      cw_d = 1'b0;
`ifdef QENC_SATURATE_EN
      if (pos_q != PMIN) begin
        pos_d = pos_q - PONE;
      end else begin
        pos_d = pos_q;
      end
`else
      pos_d = pos_q - PONE;
`endif
    end else begin
      pos_d = pos_q;
    end
    if (i_clr) begin
      pos_d = PMIN;
      err_d = 1'b0;
    end else if (bad) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
      cand_q  <= 2'b00;
      fcnt_q  <= FMAX;
      filt_q  <= 2'b00;
      last_q  <= 2'b00;
      state_q <= ST_IDLE;
      pos_q   <= PMIN;
      step_q  <= 1'b0;
      cw_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cand_q  <= cand_d;
      fcnt_q  <= fcnt_d;
      filt_q  <= filt_d;
      last_q  <= last_d;
      state_q <= state_d;
      pos_q   <= pos_d;
      step_q  <= step_d;
      cw_q    <= cw_d;
      err_q   <= err_d;
    end
  end

  assign o_step    = step_q;
  assign o_step_cw = cw_q;
  assign o_pos     = pos_q;
  assign o_err     = err_q;

endmodule

// File: rtl/quad_encoder_bank.sv
// Multi-channel quadrature decoder bank: one qenc_channel per encoder, buses
// sliced per channel. Define QENC_SATURATE_EN for saturating positions.
module quad_encoder_bank
  import qenc_pkg::*;
#(
  parameter int CHANNELS   = 2,
  parameter int CNT_WIDTH  = 8,
  parameter int FILTER_LEN = 4,
  parameter int RES        = RES_DETENT
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [CHANNELS-1:0]           i_phase_a,
  input  logic [CHANNELS-1:0]           i_phase_b,
  input  logic [CHANNELS-1:0]           i_clr,
  output logic [CHANNELS-1:0]           o_step,
  output logic [CHANNELS-1:0]           o_step_cw,
  output logic [CHANNELS*CNT_WIDTH-1:0] o_pos,
  output logic [CHANNELS-1:0]           o_err
);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    qenc_channel #(
      .CNT_WIDTH (CNT_WIDTH),
      .FILTER_LEN(FILTER_LEN),
      .RES       (RES)
    ) u_ch (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_a      (i_phase_a[g]),
      .i_b      (i_phase_b[g]),
      .i_clr    (i_clr[g]),
      .o_step   (o_step[g]),
      .o_step_cw(o_step_cw[g]),
      .o_pos    (o_pos[g*CNT_WIDTH +: CNT_WIDTH]),
      .o_err    (o_err[g])
    );
  end

endmodule

// File: tb/tb_quad_encoder_bank.sv
// Bench for quad_encoder_bank: a detent-resolution instance (index 0) and an
// edge-resolution instance (index 1), checked against a displacement-based model.
module tb_quad_encoder_bank;

  localparam int CH = 2, CW = 2, FL = 4, HOLD = 30, PMOD = 1 << CW;

  logic clk = 1'b0;
  logic rst;
  logic [CH-1:0] pa[2], pb[2], clr_i[2], step_o[2], cw_o[2], err_o[2];
  logic [CH*CW-1:0] pos_o[2];
  int n_cmp = 0, n_bad = 0;
  int n_cw[2][CH] = '{default: 0};
  int n_ccw[2][CH] = '{default: 0};
  // reference model state
  int m_pos[2][CH], m_disp[2][CH], m_cw[2][CH], m_ccw[2][CH];
  bit m_err[2][CH], m_dir[2][CH], m_resync[2][CH];
  logic [1:0] m_code[2][CH];
  logic [3:0] acw = 4'b0011, bcw = 4'b0110;

  quad_encoder_bank #(.CHANNELS(CH), .CNT_WIDTH(CW), .FILTER_LEN(FL), .RES(1)) dut (
    .i_clk(clk), .i_rst(rst), .i_phase_a(pa[0]), .i_phase_b(pb[0]), .i_clr(clr_i[0]),
    .o_step(step_o[0]), .o_step_cw(cw_o[0]), .o_pos(pos_o[0]), .o_err(err_o[0]));

  quad_encoder_bank #(.CHANNELS(CH), .CNT_WIDTH(CW), .FILTER_LEN(FL), .RES(4)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_phase_a(pa[1]), .i_phase_b(pb[1]), .i_clr(clr_i[1]),
    .o_step(step_o[1]), .o_step_cw(cw_o[1]), .o_pos(pos_o[1]), .o_err(err_o[1]));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++)
      for (int c = 0; c < CH; c++)
        if (step_o[i][c] === 1'b1) begin
          if (cw_o[i][c] === 1'b1) n_cw[i][c]++;
          else n_ccw[i][c]++;
        end
  end

  function automatic int gidx(input logic [1:0] code);
    case (code)
      2'b00: return 0;
      2'b10: return 1;
      2'b11: return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] gcode(input int idx);
    case ((idx + 4) % 4)
      0: return 2'b00;
      1: return 2'b10;
      2: return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  function automatic void m_count(input int i, input int c, input int dir);
`ifdef QENC_SATURATE_EN
    m_pos[i][c] = m_pos[i][c] + dir;
    if (m_pos[i][c] < 0) m_pos[i][c] = 0;
    if (m_pos[i][c] > PMOD - 1) m_pos[i][c] = PMOD - 1;
`else
    m_pos[i][c] = (m_pos[i][c] + dir + PMOD) % PMOD;
`endif
    m_dir[i][c] = (dir > 0);
    if (dir > 0) m_cw[i][c]++;
    else m_ccw[i][c]++;
  endfunction

  // Instance 0 counts a detent when net displacement reaches +/-4 on return to 00.
  function automatic void m_apply(input int i, input int c, input logic [1:0] nc);
    int d, dir;
    if (nc == m_code[i][c]) return;
    d = (gidx(nc) - gidx(m_code[i][c]) + 4) % 4;
    if (i == 0 && m_resync[i][c]) begin
      if (nc == 2'b00) begin m_resync[i][c] = 1'b0; m_disp[i][c] = 0; end
      m_code[i][c] = nc;
      return;
    end
    if (d == 2) begin
      m_err[i][c] = 1'b1;
      if (i == 0) begin m_resync[i][c] = (nc != 2'b00); m_disp[i][c] = 0; end
      m_code[i][c] = nc;
      return;
    end
    dir = (d == 1) ? 1 : -1;
    m_code[i][c] = nc;
    if (i == 1) begin
      m_count(i, c, dir);
    end else begin
      m_disp[i][c] += dir;
      if (nc == 2'b00) begin
        if (m_disp[i][c] == 4) m_count(i, c, 1);
        else if (m_disp[i][c] == -4) m_count(i, c, -1);
        m_disp[i][c] = 0;
      end
    end
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin pa[i] = '0; pb[i] = '0; clr_i[i] = '0; end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2; i++)
      for (int c = 0; c < CH; c++) begin
        m_pos[i][c] = 0; m_disp[i][c] = 0; m_err[i][c] = 0;
        m_dir[i][c] = 0; m_resync[i][c] = 0; m_code[i][c] = 2'b00;
      end
  endtask

  task automatic settle();
    repeat (HOLD) @(negedge clk);
    for (int i = 0; i < 2; i++)
      for (int c = 0; c < CH; c++) m_apply(i, c, {pa[i][c], pb[i][c]});
  endtask

  task automatic pulse_clr(input int i, input logic [CH-1:0] mask);
    clr_i[i] = mask;
    @(negedge clk);
    clr_i[i] = '0;
    for (int c = 0; c < CH; c++)
      if (mask[c]) begin m_pos[i][c] = 0; m_err[i][c] = 1'b0; end
  endtask

  task automatic detent(input int i, input logic [CH-1:0] cwm, input logic [CH-1:0] ccwm);
    for (int k = 0; k < 4; k++) begin
      pa[i] = (acw[k] ? cwm : '0) | (bcw[k] ? ccwm : '0);
      pb[i] = (bcw[k] ? cwm : '0) | (acw[k] ? ccwm : '0);
      settle();
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if ({step_o[i], cw_o[i], err_o[i], pos_o[i]} !== '0) begin
        n_bad++;
        $display("FAIL reset i%0d: got step=%b cw=%b err=%b pos=%h expected all 0",
                 i, step_o[i], cw_o[i], err_o[i], pos_o[i]);
      end
    end
  endtask

  task automatic test_cw();
    repeat (3) detent(0, 2'b01, 2'b00);
    for (int c = 0; c < CH; c++) begin
      logic [CW-1:0] gp;
      gp = pos_o[0][c*CW +: CW];
      n_cmp += 4;
      if (gp !== m_pos[0][c][CW-1:0]) begin n_bad++; $display("FAIL cw_pos ch%0d got %0d expected %0d", c, gp, m_pos[0][c]); end
      if (err_o[0][c] !== m_err[0][c]) begin n_bad++; $display("FAIL cw_err ch%0d got %b expected %b", c, err_o[0][c], m_err[0][c]); end
      if (n_cw[0][c] !== m_cw[0][c]) begin n_bad++; $display("FAIL cw_pulses ch%0d got %0d expected %0d", c, n_cw[0][c], m_cw[0][c]); end
      if (cw_o[0][c] !== m_dir[0][c]) begin n_bad++; $display("FAIL cw_dir ch%0d got %b expected %b", c, cw_o[0][c], m_dir[0][c]); end
    end
  endtask

  task automatic test_ccw_wrap();
    for (int d = 0; d < 4; d++) begin
      logic [CW-1:0] gp;
      detent(0, 2'b00, 2'b01);
      gp = pos_o[0][CW-1:0];
      n_cmp += 3;
      if (gp !== m_pos[0][0][CW-1:0]) begin n_bad++; $display("FAIL ccw_pos step%0d got %0d expected %0d", d, gp, m_pos[0][0]); end
      if (n_ccw[0][0] !== m_ccw[0][0]) begin n_bad++; $display("FAIL ccw_pulses step%0d got %0d expected %0d", d, n_ccw[0][0], m_ccw[0][0]); end
      if (cw_o[0][0] !== 1'b0) begin n_bad++; $display("FAIL ccw_dir step%0d got %b expected 0", d, cw_o[0][0]); end
    end
  endtask

  task automatic test_inconsistent();
    logic [1:0] seq[14];
    int p0, c0, cc0;
    // A pulse, B pulse, A-then-B released B first, B-then-A released A first
    seq = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b11, 2'b10, 2'b00,
            2'b01, 2'b11, 2'b01, 2'b00, 2'b10, 2'b00};
    p0 = m_pos[0][0]; c0 = n_cw[0][0]; cc0 = n_ccw[0][0];
    foreach (seq[k]) begin
      pa[0][0] = seq[k][1]; pb[0][0] = seq[k][0];
      settle();
    end
    n_cmp += 4;
    if (pos_o[0][CW-1:0] !== m_pos[0][0][CW-1:0]) begin n_bad++; $display("FAIL incons_pos got %0d expected %0d", pos_o[0][CW-1:0], m_pos[0][0]); end
    if (m_pos[0][0] !== p0) begin n_bad++; $display("FAIL incons_model got %0d expected %0d", m_pos[0][0], p0); end
    if (n_cw[0][0] !== c0 || n_ccw[0][0] !== cc0) begin n_bad++; $display("FAIL incons_pulses got %0d/%0d expected %0d/%0d", n_cw[0][0], n_ccw[0][0], c0, cc0); end
    if (err_o[0][0] !== 1'b0) begin n_bad++; $display("FAIL incons_err got %b expected 0", err_o[0][0]); end
  endtask

  task automatic test_glitch();
    pa[0] = 2'b01; pb[0] = 2'b01; settle();
    n_cmp += 2;
    if (err_o[0][0] !== 1'b1) begin n_bad++; $display("FAIL glitch_err got %b expected 1", err_o[0][0]); end
    if (pos_o[0][CW-1:0] !== m_pos[0][0][CW-1:0]) begin n_bad++; $display("FAIL glitch_pos got %0d expected %0d", pos_o[0][CW-1:0], m_pos[0][0]); end
    pa[0] = 2'b00; pb[0] = 2'b00; settle();
    detent(0, 2'b01, 2'b00);
    n_cmp += 2;
    if (pos_o[0][CW-1:0] !== m_pos[0][0][CW-1:0]) begin n_bad++; $display("FAIL glitch_recover_pos got %0d expected %0d", pos_o[0][CW-1:0], m_pos[0][0]); end
    if (n_cw[0][0] !== m_cw[0][0]) begin n_bad++; $display("FAIL glitch_recover_pulses got %0d expected %0d", n_cw[0][0], m_cw[0][0]); end
    pulse_clr(0, 2'b01);
    @(negedge clk);
    n_cmp += 2;
    if (pos_o[0][CW-1:0] !== 2'd0) begin n_bad++; $display("FAIL clr_pos got %0d expected 0", pos_o[0][CW-1:0]); end
    if (err_o[0][0] !== 1'b0) begin n_bad++; $display("FAIL clr_err got %b expected 0", err_o[0][0]); end
  endtask

  task automatic test_latency();
    int p0;
    p0 = m_pos[0][0];
    repeat (3) begin
      pa[0] = 2'b01; repeat (3) @(negedge clk);
      pa[0] = 2'b00; repeat (HOLD) @(negedge clk);
    end
    n_cmp += 2;
    if (pos_o[0][CW-1:0] !== p0[CW-1:0]) begin n_bad++; $display("FAIL spike_pos got %0d expected %0d", pos_o[0][CW-1:0], p0); end
    if (n_cw[0][0] !== m_cw[0][0] || n_ccw[0][0] !== m_ccw[0][0]) begin n_bad++; $display("FAIL spike_pulses got %0d/%0d expected %0d/%0d", n_cw[0][0], n_ccw[0][0], m_cw[0][0], m_ccw[0][0]); end
    pa[0] = 2'b01; settle();
    pb[0] = 2'b01; settle();
    pa[0] = 2'b00; settle();
    pb[0] = 2'b00;
    for (int e = 1; e <= FL + 3; e++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (step_o[0][0] !== (e == FL + 3)) begin n_bad++; $display("FAIL latency edge%0d got %b expected %b", e, step_o[0][0], (e == FL + 3)); end
      if (e == FL + 2) clr_i[0] = 2'b01;
    end
    n_cmp++;
    if (pos_o[0][CW-1:0] !== 2'd0) begin n_bad++; $display("FAIL clr_with_step_pos got %0d expected 0", pos_o[0][CW-1:0]); end
    @(negedge clk);
    clr_i[0] = '0;
    m_apply(0, 0, 2'b00);
    m_pos[0][0] = 0; m_err[0][0] = 1'b0;
    repeat (HOLD) @(negedge clk);
    n_cmp++;
    if (n_cw[0][0] !== m_cw[0][0]) begin n_bad++; $display("FAIL latency_pulses got %0d expected %0d", n_cw[0][0], m_cw[0][0]); end
  endtask

  task automatic test_random();
    for (int h = 0; h < 60; h++) begin
      for (int i = 0; i < 2; i++)
        for (int c = 0; c < CH; c++) begin
          int r;
          logic [1:0] nc;
          r = $urandom_range(0, 9);
          if (r < 4) nc = gcode(gidx(m_code[i][c]) + 1);
          else if (r < 8) nc = gcode(gidx(m_code[i][c]) - 1);
          else if (r == 8) nc = ~m_code[i][c];
          else nc = m_code[i][c];
          pa[i][c] = nc[1]; pb[i][c] = nc[0];
        end
      settle();
      if ($urandom_range(0, 11) == 0) pulse_clr($urandom_range(0, 1), CH'($urandom_range(1, 3)));
      for (int i = 0; i < 2; i++)
        for (int c = 0; c < CH; c++) begin
          logic [CW-1:0] gp;
          gp = pos_o[i][c*CW +: CW];
          n_cmp += 4;
          if (gp !== m_pos[i][c][CW-1:0]) begin n_bad++; $display("FAIL rand_pos h%0d i%0d c%0d got %0d expected %0d", h, i, c, gp, m_pos[i][c]); end
          if (err_o[i][c] !== m_err[i][c]) begin n_bad++; $display("FAIL rand_err h%0d i%0d c%0d got %b expected %b", h, i, c, err_o[i][c], m_err[i][c]); end
          if (n_cw[i][c] !== m_cw[i][c] || n_ccw[i][c] !== m_ccw[i][c]) begin n_bad++; $display("FAIL rand_pulses h%0d i%0d c%0d got %0d/%0d expected %0d/%0d", h, i, c, n_cw[i][c], n_ccw[i][c], m_cw[i][c], m_ccw[i][c]); end
          if (cw_o[i][c] !== m_dir[i][c]) begin n_bad++; $display("FAIL rand_dir h%0d i%0d c%0d got %b expected %b", h, i, c, cw_o[i][c], m_dir[i][c]); end
        end
    end
  endtask

  task automatic test_res4();
    int c0, cc1;
    do_reset();
    @(negedge clk);
    c0 = n_cw[1][0]; cc1 = n_ccw[1][1];
    detent(1, 2'b01, 2'b10);
    n_cmp += 4;
    if (n_cw[1][0] - c0 !== 4) begin n_bad++; $display("FAIL res4_cw_pulses got %0d expected 4", n_cw[1][0] - c0); end
    if (n_ccw[1][1] - cc1 !== 4) begin n_bad++; $display("FAIL res4_ccw_pulses got %0d expected 4", n_ccw[1][1] - cc1); end
    if (pos_o[1][CW-1:0] !== m_pos[1][0][CW-1:0]) begin n_bad++; $display("FAIL res4_pos0 got %0d expected %0d", pos_o[1][CW-1:0], m_pos[1][0]); end
    if (pos_o[1][2*CW-1:CW] !== m_pos[1][1][CW-1:0]) begin n_bad++; $display("FAIL res4_pos1 got %0d expected %0d", pos_o[1][2*CW-1:CW], m_pos[1][1]); end
    // part of a detent on every channel of both instances, then reset
    pa[0] = 2'b11; pb[0] = 2'b00; pa[1] = 2'b01; pb[1] = 2'b10; settle();
    pb[0] = 2'b11; pa[1] = 2'b11; pb[1] = 2'b11; settle();
    do_reset();
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        n_cmp++;
        if ({step_o[i], cw_o[i], err_o[i], pos_o[i]} !== '0) begin
          n_bad++;
          $display("FAIL mid_reset t%0d i%0d: got step=%b cw=%b err=%b pos=%h expected all 0",
                   t, i, step_o[i], cw_o[i], err_o[i], pos_o[i]);
        end
      end
      repeat (HOLD) @(negedge clk);
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++)
      for (int c = 0; c < CH; c++) begin m_cw[i][c] = 0; m_ccw[i][c] = 0; end
    test_reset();
    test_cw();
    test_ccw_wrap();
    test_inconsistent();
    test_glitch();
    test_latency();
    test_random();
    test_res4();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
